vc_pipe_domain_arb: RTL and testbench
=====================================

VC_PIPE_DOMAIN_ARB -- requirements
Module: vc_pipe_domain_arb

Interface
REQ-001 Parameter SLOT_CYCLES, default 16: length of each security-domain time slot in cycles.
REQ-002 Parameter OP_LAT, default 4: fixed occupancy of the shared pipeline resource per grant, in cycles.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_val  in  2  bit d is the valid request from the domain-d pipeline stage.
REQ-006 req_stall  out  2  bit d is the stall to the domain-d stage; it feeds that stage's curr_stall.
REQ-007 grant  out  2  one-hot or zero; bit d is the one-cycle issue pulse to domain d.
REQ-008 slot_owner  out  1  domain owning the current slot.
REQ-009 busy  out  1  the resource is occupied by an issued operation.

Function
REQ-010 The arbiter SHALL implement FSM states IDLE and BUSY.
- IDLE -> BUSY on grant when OP_LAT>1.
- BUSY -> IDLE when busy_cnt reaches 0.
REQ-011 slot_rem SHALL count SLOT_CYCLES down to 1, decrementing each cycle.
- At slot_rem==1, the next cycle reloads SLOT_CYCLES and toggles slot_owner.
- This happens regardless of FSM state or requests.
REQ-012 The arbiter SHALL grant owner d combinationally in a cycle when state==IDLE, req_val[d]==1 and slot_rem>=OP_LAT.
- This rule guarantees every operation completes inside its slot.
REQ-013 On a grant, busy_cnt SHALL load OP_LAT-1.
- In BUSY, busy_cnt decrements each cycle.
- busy SHALL be 1 while state==BUSY.
REQ-014 req_stall[d] SHALL equal req_val[d] && !grant[d].
REQ-015 grant SHALL never assert in BUSY.
REQ-016 grant SHALL never assert when slot_rem<OP_LAT; this is the drain window.
REQ-017 In strict mode, grant[~slot_owner] SHALL never assert.
REQ-018 Simultaneous requests SHALL be resolved by slot_owner only; there is no priority bit.
REQ-019 When a slot boundary coincides with BUSY→IDLE, the new owner SHALL be grantable in the first cycle of the new slot.
REQ-020 If OP_LAT==1, the FSM SHALL remain in IDLE and back-to-back grants SHALL be allowed every cycle.
REQ-021 Elaboration SHALL fail if SLOT_CYCLES<OP_LAT or OP_LAT<1.

Reset
REQ-022 On reset, the arbiter SHALL return to its initial state:
- state=IDLE, busy_cnt=0;
- slot_owner=0, slot_rem=SLOT_CYCLES;
- grant=0, busy=0.
REQ-023 A reset asserted mid-operation SHALL abandon the operation; no grant is issued while reset is high.
REQ-024 req_stall SHALL equal req_val while reset is high.

Configuration
REQ-025 Macro VC_PIPE_DOMAIN_ARB_WORK_CONSERVING_EN controls lending of idle slots.
- Defined: when req_val[slot_owner]==0, the other domain MAY be granted under the REQ-012 conditions. That operation still finishes inside the current slot.
- Undefined (default, secure): strict time partitioning per REQ-017.

Structure
REQ-026 Package vc_pipe_arb_pkg SHALL hold:
- state enum {IDLE, BUSY};
- default constants SLOT_CYCLES_DFLT=16 and OP_LAT_DFLT=4;
- the domain index width of 1.
REQ-027 Sub-module vc_pipe_arb_slot_timer SHALL own slot_rem and slot_owner and export both.
REQ-028 The top level SHALL hold the FSM, busy_cnt and the grant/stall logic.

Verification (SLOT_CYCLES=8, OP_LAT=3 unless noted)
REQ-029 The bench SHALL cover these scenarios:
- Reset, then hold req_val=00 → slot_owner toggles at cycles 8, 16, 24; grant stays 00.
- req_val=01 from cycle 0 → grant[0] at cycles 0 and 3; no grant in cycles 6-7 (drain); next grant[0] at cycle 16.
- req_val=11 from cycle 0 → domain 0 granted in slot 0 and domain 1 in slot 1; req_stall=10 during domain 0's grant cycle.
- req_val=10 in slot 0, strict build → grant stays 00 until cycle 8, then grant=10.
  - Work-conserving build → grant=10 at cycle 0.
- Reset asserted at cycle 1, mid-BUSY → next cycle: state IDLE, busy=0, slot_rem=8, slot_owner=0.
- OP_LAT=1 with req_val=01 → grant[0] every cycle of slot 0 and none in slot 1.

Source files
------------

// File: rtl/vc_pipe_arb_pkg.sv
// Shared types and constants for the two-domain time-sliced pipeline arbiter.
// The lending feature is selected with VC_PIPE_DOMAIN_ARB_WORK_CONSERVING_EN.
package vc_pipe_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int SLOT_CYCLES_DFLT = 16;
    localparam int OP_LAT_DFLT      = 4;
    localparam int DOM_W            = 1;
    localparam int NUM_DOM          = 2;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/vc_pipe_domain_arb_if.sv
// Request/stall/grant bundle between the two domain pipeline stages and the arbiter.
interface vc_pipe_domain_arb_if;
    import vc_pipe_arb_pkg::*;

    logic [NUM_DOM-1:0] req_val;
    logic [NUM_DOM-1:0] req_stall;
    logic [NUM_DOM-1:0] grant;
    logic [DOM_W-1:0]   slot_owner;
    logic               busy;

    modport master (
        output req_val,
        input  req_stall,
        input  grant,
        input  slot_owner,
        input  busy
    );

    modport slave (
        input  req_val,
        output req_stall,
        output grant,
        output slot_owner,
        output busy
    );

endinterface

// File: rtl/vc_pipe_arb_slot_timer.sv
// Free-running security-domain slot timer: counts SLOT_CYCLES..1 and flips the owner
// on every wrap, independent of requests or arbiter state.
module vc_pipe_arb_slot_timer
    import vc_pipe_arb_pkg::*;
#(
    parameter int SLOT_CYCLES = SLOT_CYCLES_DFLT,
    parameter int RW          = cnt_width(SLOT_CYCLES)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [RW-1:0]    slot_rem,
    output logic [DOM_W-1:0] slot_owner
);

    logic [RW-1:0]    slot_rem_reg,   slot_rem_next;
    logic [DOM_W-1:0] slot_owner_reg, slot_owner_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_rem_reg   <= RW'(SLOT_CYCLES);
            slot_owner_reg <= '0;
        end else begin
            slot_rem_reg   <= slot_rem_next;
            slot_owner_reg <= slot_owner_next;
        end
    end

    always_comb begin
        slot_rem_next   = slot_rem_reg - RW'(1);
        slot_owner_next = slot_owner_reg;
        if (slot_rem_reg == RW'(1)) begin
            slot_rem_next   = RW'(SLOT_CYCLES);
            slot_owner_next = ~slot_owner_reg;
        end
    end

    assign slot_rem   = slot_rem_reg;
    assign slot_owner = slot_owner_reg;

endmodule

// File: rtl/vc_pipe_domain_arb.sv
// Time-partitioned arbiter giving two pipeline domains access to one shared OP_LAT-cycle
// resource. VC_PIPE_DOMAIN_ARB_WORK_CONSERVING_EN lends an idle slot to the other domain.
module vc_pipe_domain_arb
    import vc_pipe_arb_pkg::*;
#(
    parameter int SLOT_CYCLES = SLOT_CYCLES_DFLT,
    parameter int OP_LAT      = OP_LAT_DFLT
) (
    input  logic                 clk,
    input  logic                 reset,
    vc_pipe_domain_arb_if.slave  bus
);

    localparam int RW = cnt_width(SLOT_CYCLES);
    localparam int CW = cnt_width(OP_LAT - 1);

    generate
        if (SLOT_CYCLES < OP_LAT || OP_LAT < 1) begin : g_bad_cfg
            $error("vc_pipe_domain_arb: need 1 <= OP_LAT <= SLOT_CYCLES");
        end
    endgenerate

    arb_state_t         state_reg, state_next;
    logic [CW-1:0]      busy_cnt_reg, busy_cnt_next;
    logic [RW-1:0]      slot_rem;
    logic [DOM_W-1:0]   slot_owner;
    logic [NUM_DOM-1:0] req_val;
    logic [NUM_DOM-1:0] grant_d;
    logic               can_issue;
    logic               lend_ok;
    logic               busy;

    vc_pipe_arb_slot_timer #(
        .SLOT_CYCLES (SLOT_CYCLES),
        .RW          (RW)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .slot_rem   (slot_rem),
        .slot_owner (slot_owner)
    );

    assign req_val = bus.req_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            busy_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            busy_cnt_reg <= busy_cnt_next;
        end
    end

    // The final count of an operation returns to IDLE, so the resource is free again
    // exactly OP_LAT cycles after the grant.
    always_comb begin
        state_next    = state_reg;
        busy_cnt_next = busy_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (|grant_d) begin
                    busy_cnt_next = CW'(OP_LAT - 1);
                    if (OP_LAT > 1) begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                busy_cnt_next = busy_cnt_reg - CW'(1);
                if (busy_cnt_reg == CW'(1)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next    = IDLE;
                busy_cnt_next = '0;
            end
        endcase
    end

    // Issuing only while slot_rem >= OP_LAT keeps every operation inside its own slot.
    always_comb begin
        can_issue = 1'b0;
        busy      = 1'b0;
        if (!reset && state_reg == IDLE && slot_rem >= RW'(OP_LAT)) begin
            can_issue = 1'b1;
        end
        if (state_reg == BUSY) begin
            busy = 1'b1;
        end
    end

`ifdef VC_PIPE_DOMAIN_ARB_WORK_CONSERVING_EN
    assign lend_ok = !req_val[slot_owner];
`else
    assign lend_ok = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < NUM_DOM; gi++) begin : g_dom
            assign grant_d[gi] = can_issue && req_val[gi]
                               && ((slot_owner == DOM_W'(gi)) || lend_ok);
            assign bus.req_stall[gi] = req_val[gi] && !grant_d[gi];
        end
    endgenerate

    assign bus.grant      = grant_d;
    assign bus.slot_owner = slot_owner;
    assign bus.busy       = busy;

endmodule

// File: tb/tb_vc_pipe_domain_arb.sv
// Directed bench: SLOT_CYCLES=8 with OP_LAT=3 (main) and OP_LAT=1 (back-to-back) instances.
module tb_vc_pipe_domain_arb;
    import vc_pipe_arb_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    vc_pipe_domain_arb_if bus3();
    vc_pipe_domain_arb_if bus1();

    vc_pipe_domain_arb #(.SLOT_CYCLES(8), .OP_LAT(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    vc_pipe_domain_arb #(.SLOT_CYCLES(8), .OP_LAT(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic [1:0] grant;
        logic [1:0] stall;
        logic       owner;
        logic       busy;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, c, act, exp);
        end
    endtask

    task automatic set_req(input logic [1:0] r);
        bus3.req_val = r;
        bus1.req_val = r;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One reset cycle with the given request pattern; returns at the start of cycle 0.
    task automatic do_reset(input logic [1:0] r);
        set_req(r);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_grant3", -1, 32'(bus3.grant), 32'(2'b00));
        chk("rst_stall3", -1, 32'(bus3.req_stall), 32'(r));
        chk("rst_grant1", -1, 32'(bus1.grant), 32'(2'b00));
        chk("rst_stall1", -1, 32'(bus1.req_stall), 32'(r));
        next_cycle();
        reset = 1'b0;
    endtask

    logic [1:0] exp_g;
    logic       exp_b;

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        set_req(2'b00);

        vecs[0]  = '{2'b11, 2'b01, 2'b10, 1'b0, 1'b0};
        vecs[1]  = '{2'b11, 2'b00, 2'b11, 1'b0, 1'b1};
        vecs[2]  = '{2'b11, 2'b00, 2'b11, 1'b0, 1'b1};
        vecs[3]  = '{2'b11, 2'b01, 2'b10, 1'b0, 1'b0};
        vecs[4]  = '{2'b11, 2'b00, 2'b11, 1'b0, 1'b1};
        vecs[5]  = '{2'b11, 2'b00, 2'b11, 1'b0, 1'b1};
        vecs[6]  = '{2'b11, 2'b00, 2'b11, 1'b0, 1'b0};
        vecs[7]  = '{2'b11, 2'b00, 2'b11, 1'b0, 1'b0};
        vecs[8]  = '{2'b11, 2'b10, 2'b01, 1'b1, 1'b0};
        vecs[9]  = '{2'b11, 2'b00, 2'b11, 1'b1, 1'b1};
        vecs[10] = '{2'b11, 2'b00, 2'b11, 1'b1, 1'b1};
        vecs[11] = '{2'b11, 2'b10, 2'b01, 1'b1, 1'b0};
        vecs[12] = '{2'b11, 2'b00, 2'b11, 1'b1, 1'b1};
        vecs[13] = '{2'b11, 2'b00, 2'b11, 1'b1, 1'b1};
        vecs[14] = '{2'b11, 2'b00, 2'b11, 1'b1, 1'b0};
        vecs[15] = '{2'b11, 2'b00, 2'b11, 1'b1, 1'b0};
        vecs[16] = '{2'b11, 2'b01, 2'b10, 1'b0, 1'b0};

        // Idle requests: reset state, then the owner flips every 8 cycles.
        do_reset(2'b00);
        for (int c = 0; c < 26; c++) begin
            set_req(2'b00);
            @(negedge clk);
            if (c == 0) begin
                chk("reset_slot_rem", c, 32'(dut3.u_timer.slot_rem_reg), 32'd8);
                chk("reset_busy", c, 32'(bus3.busy), 32'd0);
            end
            chk("idle_owner", c, 32'(bus3.slot_owner), 32'((c / 8) % 2));
            chk("idle_grant", c, 32'(bus3.grant), 32'(2'b00));
            next_cycle();
        end
        $display("seq idle: done");

        // Domain 0 only: two grants in slot 0, drain window, then slot 2.
        do_reset(2'b01);
        for (int c = 0; c < 19; c++) begin
            set_req(2'b01);
            @(negedge clk);
            exp_g = 2'b00;
            exp_b = 1'b0;
`ifdef VC_PIPE_DOMAIN_ARB_WORK_CONSERVING_EN
            if (c inside {0, 3, 8, 11, 16}) exp_g = 2'b01;
            if (c inside {1, 2, 4, 5, 9, 10, 12, 13, 17, 18}) exp_b = 1'b1;
`else
            if (c inside {0, 3, 16}) exp_g = 2'b01;
            if (c inside {1, 2, 4, 5, 17, 18}) exp_b = 1'b1;
`endif
            chk("d0_grant", c, 32'(bus3.grant), 32'(exp_g));
            chk("d0_busy", c, 32'(bus3.busy), 32'(exp_b));
            next_cycle();
        end
        $display("seq d0_only: done");

        // Both domains requesting: table-driven per-cycle vectors.
        do_reset(2'b11);
        for (int i = 0; i < 17; i++) begin
            set_req(vecs[i].req);
            @(negedge clk);
            chk("tbl_grant", i, 32'(bus3.grant), 32'(vecs[i].grant));
            chk("tbl_stall", i, 32'(bus3.req_stall), 32'(vecs[i].stall));
            chk("tbl_owner", i, 32'(bus3.slot_owner), 32'(vecs[i].owner));
            chk("tbl_busy", i, 32'(bus3.busy), 32'(vecs[i].busy));
            $display("vec %0d: req=%b grant=%b stall=%b owner=%0d busy=%0d",
                     i, vecs[i].req, bus3.grant, bus3.req_stall, bus3.slot_owner, bus3.busy);
            next_cycle();
        end

        // Domain 1 only during slot 0.
        do_reset(2'b10);
        for (int c = 0; c < 9; c++) begin
            set_req(2'b10);
            @(negedge clk);
            exp_g = 2'b00;
`ifdef VC_PIPE_DOMAIN_ARB_WORK_CONSERVING_EN
            if (c inside {0, 3, 8}) exp_g = 2'b10;
`else
            if (c == 8) exp_g = 2'b10;
`endif
            chk("d1_grant", c, 32'(bus3.grant), 32'(exp_g));
            next_cycle();
        end
        $display("seq d1_only: done");

        // Operation ends exactly at the slot boundary; new owner issues immediately.
        do_reset(2'b00);
        for (int c = 0; c < 10; c++) begin
            set_req((c < 5) ? 2'b00 : 2'b11);
            @(negedge clk);
            exp_g = 2'b00;
            if (c == 5) exp_g = 2'b01;
            if (c == 8) exp_g = 2'b10;
            chk("bnd_grant", c, 32'(bus3.grant), 32'(exp_g));
            chk("bnd_busy", c, 32'(bus3.busy), 32'(c inside {6, 7, 9}));
            next_cycle();
        end
        $display("seq boundary: done");

        // Reset during BUSY abandons the operation.
        do_reset(2'b01);
        set_req(2'b01);
        @(negedge clk);
        chk("mid_grant0", 0, 32'(bus3.grant), 32'(2'b01));
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_grant", 1, 32'(bus3.grant), 32'(2'b00));
        chk("mid_rst_stall", 1, 32'(bus3.req_stall), 32'(2'b01));
        chk("mid_rst_busy", 1, 32'(bus3.busy), 32'd1);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_state", 2, 32'(dut3.state_reg), 32'(IDLE));
        chk("mid_busy", 2, 32'(bus3.busy), 32'd0);
        chk("mid_slot_rem", 2, 32'(dut3.u_timer.slot_rem_reg), 32'd8);
        chk("mid_owner", 2, 32'(bus3.slot_owner), 32'd0);
        chk("mid_regrant", 2, 32'(bus3.grant), 32'(2'b01));
        next_cycle();
        $display("seq mid_reset: done");

        // OP_LAT=1: back-to-back grants, FSM never leaves IDLE.
        do_reset(2'b01);
        for (int c = 0; c < 16; c++) begin
            set_req(2'b01);
            @(negedge clk);
`ifdef VC_PIPE_DOMAIN_ARB_WORK_CONSERVING_EN
            exp_g = 2'b01;
`else
            exp_g = (c < 8) ? 2'b01 : 2'b00;
`endif
            chk("lat1_grant", c, 32'(bus1.grant), 32'(exp_g));
            chk("lat1_busy", c, 32'(bus1.busy), 32'd0);
            next_cycle();
        end
        $display("seq lat1: done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
